// File: rtl/sft_arbiter_if.sv
// Request/grant bundle between requesters (master) and the arbiter (slave).
interface sft_arbiter_if #(
  parameter int PORTS = 4
);
  localparam int EW = $clog2(PORTS);

  logic [PORTS-1:0] request;
  logic [PORTS-1:0] acknowledge;
  logic [PORTS-1:0] grant;
  logic             grant_valid;
  logic [EW-1:0]    grant_encoded;

  modport master (
    output request,
    output acknowledge,
    input  grant,
    input  grant_valid,
    input  grant_encoded
  );

  modport slave (
    input  request,
    input  acknowledge,
    output grant,
    output grant_valid,
    output grant_encoded
  );
endinterface

// File: rtl/sft_arbiter.sv
// Fixed-priority / round-robin arbiter with optional grant holding.
//   state   | meaning
//   ST_FREE | no grant held; arbitrate on every edge
//   ST_HELD | grant locked until request drop or acknowledge of the winner
module sft_arbiter #(
  parameter int PORTS                = 4,
  parameter int ARB_TYPE_ROUND_ROBIN = 0,
  parameter int ARB_BLOCK            = 0,
  parameter int ARB_BLOCK_ACK        = 1,
  parameter int LSB_HIGH_PRIORITY    = 0
) (
  input  logic         clk,
  input  logic         rst,
  sft_arbiter_if.slave bus
);
  localparam int EW = $clog2(PORTS);

  typedef enum logic {ST_FREE, ST_HELD} state_t;

  state_t           r_state, w_state_nxt;
  logic [PORTS-1:0] r_grant, w_grant_nxt;
  logic [PORTS-1:0] r_mask, w_mask_nxt;
  logic             r_valid, w_valid_nxt;
  logic [EW-1:0]    r_enc, w_enc_nxt;

  logic [PORTS-1:0] w_masked_req;
  logic [PORTS-1:0] w_pick_src;
  logic [EW-1:0]    w_pick_idx;
  logic             w_release;
  logic             w_arbitrate;

  function automatic logic [EW-1:0] f_prio_enc(input logic [PORTS-1:0] v);
    logic [EW-1:0] idx;
    idx = '0;
    if (LSB_HIGH_PRIORITY != 0) begin
      for (int i = PORTS - 1; i >= 0; i--) begin
        if (v[i]) idx = EW'(i);
      end
    end else begin
      for (int i = 0; i < PORTS; i++) begin
        if (v[i]) idx = EW'(i);
      end
    end
    return idx;
  endfunction

  // Ones on every port strictly below the priority of the given index.
  function automatic logic [PORTS-1:0] f_lower_mask(input logic [EW-1:0] idx);
    logic [PORTS-1:0] m;
    m = '0;
    for (int j = 0; j < PORTS; j++) begin
      if (LSB_HIGH_PRIORITY != 0) m[j] = (j > int'(idx));
      else                        m[j] = (j < int'(idx));
    end
    return m;
  endfunction

  always_comb begin
    w_masked_req = bus.request & r_mask;
    w_pick_src   = bus.request;
    if ((ARB_TYPE_ROUND_ROBIN != 0) && (|w_masked_req)) w_pick_src = w_masked_req;
    w_pick_idx   = f_prio_enc(w_pick_src);
  end

  always_comb begin
    w_release = 1'b0;
    if (r_state == ST_HELD) begin
      if (ARB_BLOCK_ACK != 0) w_release = bus.acknowledge[r_enc];
      else                    w_release = !bus.request[r_enc];
    end
    w_arbitrate = (r_state == ST_FREE) || w_release;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_valid_nxt = r_valid;
    w_enc_nxt   = r_enc;
    w_mask_nxt  = r_mask;
    if (w_arbitrate) begin
      if (|bus.request) begin
        w_grant_nxt             = '0;
        w_grant_nxt[w_pick_idx] = 1'b1;
        w_valid_nxt             = 1'b1;
        w_enc_nxt               = w_pick_idx;
        if (ARB_TYPE_ROUND_ROBIN != 0) w_mask_nxt = f_lower_mask(w_pick_idx);
        w_state_nxt             = (ARB_BLOCK != 0) ? ST_HELD : ST_FREE;
      end else begin
        // Idle: outputs cleared, mask kept so rotation resumes where it left off.
        w_grant_nxt = '0;
        w_valid_nxt = 1'b0;
        w_enc_nxt   = '0;
        w_state_nxt = ST_FREE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_FREE;
      r_grant <= '0;
      r_valid <= 1'b0;
      r_enc   <= '0;
      r_mask  <= '1;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_valid <= w_valid_nxt;
      r_enc   <= w_enc_nxt;
      r_mask  <= w_mask_nxt;
    end
  end

  assign bus.grant         = r_grant;
  assign bus.grant_valid   = r_valid;
  assign bus.grant_encoded = r_enc;
endmodule

// File: tb/tb_sft_arbiter.sv
// Directed scoreboard bench over four arbiter configurations sharing one clock.
module tb_sft_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sft_arbiter_if #(.PORTS(4)) if_rr ();
  sft_arbiter_if #(.PORTS(4)) if_fx ();
  sft_arbiter_if #(.PORTS(4)) if_ba ();
  sft_arbiter_if #(.PORTS(4)) if_br ();

  sft_arbiter #(.PORTS(4), .ARB_TYPE_ROUND_ROBIN(1), .ARB_BLOCK(0), .ARB_BLOCK_ACK(1),
                .LSB_HIGH_PRIORITY(1)) u_rr (.clk(clk), .rst(rst), .bus(if_rr.slave));
  sft_arbiter #(.PORTS(4), .ARB_TYPE_ROUND_ROBIN(0), .ARB_BLOCK(0), .ARB_BLOCK_ACK(1),
                .LSB_HIGH_PRIORITY(0)) u_fx (.clk(clk), .rst(rst), .bus(if_fx.slave));
  sft_arbiter #(.PORTS(4), .ARB_TYPE_ROUND_ROBIN(1), .ARB_BLOCK(1), .ARB_BLOCK_ACK(1),
                .LSB_HIGH_PRIORITY(1)) u_ba (.clk(clk), .rst(rst), .bus(if_ba.slave));
  sft_arbiter #(.PORTS(4), .ARB_TYPE_ROUND_ROBIN(1), .ARB_BLOCK(1), .ARB_BLOCK_ACK(0),
                .LSB_HIGH_PRIORITY(1)) u_br (.clk(clk), .rst(rst), .bus(if_br.slave));

  typedef struct {
    string      tag;
    int         dut;
    logic [6:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic logic [6:0] observe(int d);
    case (d)
      0:       return {if_rr.grant_valid, if_rr.grant_encoded, if_rr.grant};
      1:       return {if_fx.grant_valid, if_fx.grant_encoded, if_fx.grant};
      2:       return {if_ba.grant_valid, if_ba.grant_encoded, if_ba.grant};
      default: return {if_br.grant_valid, if_br.grant_encoded, if_br.grant};
    endcase
  endfunction

  task automatic push(int d, string tag, logic [3:0] g, logic [1:0] e);
    exp_t x;
    x.tag = tag;
    x.dut = d;
    x.exp = {(g != 4'b0000), e, g};
    sb.push_back(x);
  endtask

  task automatic tick();
    exp_t       x;
    logic [6:0] o;
    @(posedge clk);
    #1;
    for (int d = 0; d < 4; d++) begin
      o = observe(d);
      n_tests++;
      assert ($onehot0(o[3:0]) && (o[6] === (|o[3:0])))
      else begin
        n_fail++;
        $error("FAIL invariant dut%0d observed v/e/g=%b expected onehot0 grant with valid==|grant", d, o);
      end
    end
    while (sb.size() > 0) begin
      x = sb.pop_front();
      o = observe(x.dut);
      n_tests++;
      assert (o === x.exp)
      else begin
        n_fail++;
        $error("FAIL %s dut%0d observed v/e/g=%b expected %b", x.tag, x.dut, o, x.exp);
      end
    end
  endtask

  logic [3:0] br_req [6] = '{4'b0100, 4'b0110, 4'b0001, 4'b0001, 4'b0011, 4'b0010};
  logic [3:0] br_gnt [6] = '{4'b0100, 4'b0100, 4'b0001, 4'b0001, 4'b0001, 4'b0010};
  logic [1:0] br_enc [6] = '{2'd2, 2'd2, 2'd0, 2'd0, 2'd0, 2'd1};
  logic [3:0] ba_ack [6] = '{4'b0000, 4'b0000, 4'b0100, 4'b0000, 4'b0000, 4'b0001};

  initial begin
    if_rr.request = '0; if_rr.acknowledge = '0;
    if_fx.request = '0; if_fx.acknowledge = '0;
    if_ba.request = '0; if_ba.acknowledge = '0;
    if_br.request = '0; if_br.acknowledge = '0;
    rst = 1'b1;
    tick();
    if_rr.request = 4'b1111; if_ba.request = 4'b1111;
    for (int d = 0; d < 4; d++) push(d, "reset", 4'b0000, 2'd0);
    tick();
    rst = 1'b0;

    for (int k = 0; k < 6; k++) begin
      if_rr.request = 4'b1111;
      push(0, "rr_rotate", 4'(1 << (k % 4)), 2'(k % 4));
      if_fx.request = 4'b0101;
      push(1, "fix_msb_prio", 4'b0100, 2'd2);
      if_ba.request = 4'b1111;
      if_ba.acknowledge = ba_ack[k];
      if (k < 5) push(2, "blk_ack_hold", 4'b0001, 2'd0);
      else       push(2, "blk_ack_release", 4'b0010, 2'd1);
      if_br.request = br_req[k];
      if_br.acknowledge = 4'b1111;
      push(3, "blk_req_drop", br_gnt[k], br_enc[k]);
      tick();
    end

    if_rr.request = 4'b1111; push(0, "rr_rotate", 4'b0100, 2'd2);
    if_fx.request = 4'b0011; push(1, "fix_pattern2", 4'b0010, 2'd1);
    if_ba.acknowledge = 4'b0000; push(2, "blk_ack_hold2", 4'b0010, 2'd1);
    if_br.request = 4'b0000; push(3, "blk_req_idle", 4'b0000, 2'd0);
    tick();

    push(0, "rr_rotate", 4'b1000, 2'd3);
    if_fx.request = 4'b0000; push(1, "fix_idle", 4'b0000, 2'd0);
    push(2, "blk_ack_hold2", 4'b0010, 2'd1);
    push(3, "blk_req_idle", 4'b0000, 2'd0);
    tick();

    if_rr.request = 4'b0001; push(0, "rr_wrap_fallback", 4'b0001, 2'd0);
    if_fx.request = 4'b1000; push(1, "fix_top", 4'b1000, 2'd3);
    push(2, "blk_ack_hold2", 4'b0010, 2'd1);
    tick();

    if_rr.request = 4'b0000; push(0, "rr_idle", 4'b0000, 2'd0);
    tick();

    if_rr.request = 4'b1001; push(0, "rr_mask_kept", 4'b1000, 2'd3);
    tick();

    push(0, "rr_wrap_again", 4'b0001, 2'd0);
    tick();

    rst = 1'b1;
    for (int d = 0; d < 4; d++) push(d, "sync_reset", 4'b0000, 2'd0);
    tick();

    rst = 1'b0;
    if_rr.request = 4'b1111; push(0, "rr_after_reset", 4'b0001, 2'd0);
    push(1, "fix_after_reset", 4'b1000, 2'd3);
    push(2, "blk_ack_after_reset", 4'b0001, 2'd0);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/sft_arbiter.md
SFT_ARBITER -- requirements
Module: sft_arbiter

Interface
REQ-001 SHALL have parameter PORTS, default 4, number of requesters (>=2).
REQ-002 SHALL have parameter ARB_TYPE_ROUND_ROBIN, default 0; 1 = round-robin, 0 = fixed priority.
REQ-003 SHALL have parameter ARB_BLOCK, default 0; 1 = hold grant until release, 0 = re-arbitrate every cycle.
REQ-004 SHALL have parameter ARB_BLOCK_ACK, default 1; with ARB_BLOCK=1, 1 = release on acknowledge, 0 = release on request drop.
REQ-005 SHALL have parameter LSB_HIGH_PRIORITY, default 0; 1 = index 0 highest priority, 0 = index PORTS-1 highest.
REQ-006 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-007 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-008 SHALL have port request  input  PORTS  per-requester request level.
REQ-009 SHALL have port acknowledge  input  PORTS  per-requester release strobe; used only when ARB_BLOCK=1 and ARB_BLOCK_ACK=1.
REQ-010 SHALL have port grant  output  PORTS  registered one-hot grant, or zero.
REQ-011 SHALL have port grant_valid  output  1  registered; high when grant is nonzero.
REQ-012 SHALL have port grant_encoded  output  $clog2(PORTS)  registered binary index of granted port; 0 when grant_valid low.

Function
REQ-013 SHALL register all outputs; a request sampled at edge N produces grant visible after edge N, i.e. one-cycle latency.
REQ-014 SHALL select the winner with a priority encode in the LSB_HIGH_PRIORITY direction; fixed mode encodes request directly.
REQ-015 SHALL, in round-robin mode, keep a PORTS-bit mask register; winner = priority encode of (request & mask) if nonzero, else priority encode of request.
REQ-016 SHALL, after granting index i in round-robin mode, load mask with ones strictly below-priority of i (LSB_HIGH_PRIORITY=1: bits >i set; =0: bits <i set).
REQ-017 SHALL, when mask & request is zero (wrap-around), fall back to unmasked request in the same cycle, with no idle cycle.
REQ-018 SHALL, with ARB_BLOCK=0, re-arbitrate every cycle; the mask updates on every valid grant.
REQ-019 SHALL, with ARB_BLOCK=1, ARB_BLOCK_ACK=0, hold grant while request[grant_encoded] is high; in the cycle it is sampled low, re-arbitrate among current requests.
REQ-020 SHALL, with ARB_BLOCK=1, ARB_BLOCK_ACK=1, hold grant regardless of request until acknowledge[grant_encoded] is sampled high; in that cycle, re-arbitrate, and the released port may win again only per mask/priority rules.
REQ-021 SHALL ignore acknowledge bits of non-granted ports and all acknowledge when ARB_BLOCK_ACK=0 or ARB_BLOCK=0.
REQ-022 SHALL, with no requests at arbitration, drive grant=0, grant_valid=0, grant_encoded=0 next cycle and leave mask unchanged.
REQ-023 SHALL never assert more than one grant bit; grant_valid SHALL equal |grant every cycle.
REQ-024 SHALL not update mask while a grant is held.

Reset
REQ-025 SHALL, on rst high at an edge, set grant=0, grant_valid=0, grant_encoded=0, mask=all ones, and drop any held grant, overriding all other inputs.
REQ-026 SHALL arbitrate normally from the first edge with rst low; a grant held before reset is not restored.

Verification
REQ-027 SHALL pass: PORTS=4, RR, ARB_BLOCK=0, LSB_HIGH_PRIORITY=1, request=4'b1111 constant -> grant_encoded 0,1,2,3,0,1 on consecutive cycles.
REQ-028 SHALL pass: fixed, LSB_HIGH_PRIORITY=0, request=4'b0101 -> grant=4'b0100, grant_encoded=2, grant_valid=1 one cycle later.
REQ-029 SHALL pass: RR, ARB_BLOCK=1, ARB_BLOCK_ACK=1, LSB_HIGH_PRIORITY=1, request=4'b1111, acknowledge[0] pulsed at cycle 5 -> grant_encoded=0 cycles 1-5, 1 from cycle 6.
REQ-030 SHALL pass: RR, ARB_BLOCK=1, ARB_BLOCK_ACK=0, port 2 granted, request drops 4'b0100->4'b0001 -> grant 4'b0001 next cycle, no zero-grant gap.
REQ-031 SHALL pass: RR, last grant index 3, request=4'b0001 -> grant=4'b0001 via wrap fallback.
REQ-032 SHALL pass: rst asserted one cycle while grant=4'b0010 held, request=4'b1111 -> outputs zero that cycle; next grant index 0 (LSB_HIGH_PRIORITY=1).
